// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: classifies FPU results into a first-word-fall-through FIFO,
// tracks in-flight ops to gate the issuer, and keeps sticky status flags.
module fpu_result_buffer #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DEPTH = 4,
  parameter int PIPE_LATENCY = 2,
  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_fire,
  input  logic          fpu_valid,
  input  logic [W-1:0]  fpu_result,
  input  logic          fpu_exception,
  output logic          issue_ok,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [2:0]    out_class,
  output logic          out_exception,
  output logic [CW-1:0] count,
  output logic [3:0]    sticky_flags,
  input  logic          flags_clear
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(DEPTH + PIPE_LATENCY + 1) + 1;
  localparam int SW = IW + 1;
  localparam logic [CW-1:0] full_count = CW'(DEPTH);
  localparam logic [PW-1:0] last_ptr = PW'(DEPTH - 1);
  localparam logic [SW-1:0] depth_sum = SW'(DEPTH);
  localparam logic [IW-1:0] inflight_max = '1;
  logic [W-1:0] mem_result [DEPTH];
  logic [2:0] mem_class [DEPTH];
  logic mem_exception [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [IW-1:0] inflight;
  logic [EXPONENT_WIDTH-1:0] exp_f;
  logic [MANTISSA_WIDTH-1:0] mant;
  logic [2:0] cls;
  logic tracked, stray, pop, push, drop, over_issue;
  always_comb begin
    exp_f = fpu_result[W-2:MANTISSA_WIDTH];
    mant = fpu_result[MANTISSA_WIDTH-1:0];
    cls = exp_f == '0 ? (mant == '0 ? 3'd0 : 3'd1)
        : &exp_f ? (mant == '0 ? 3'd3 : mant[MANTISSA_WIDTH-1] ? 3'd4 : 3'd5)
        : 3'd2;
    tracked = fpu_valid && inflight != '0;
    stray = fpu_valid && inflight == '0;
    pop = out_valid && out_ready;
    push = tracked && (count != full_count || pop);
    drop = fpu_valid && !push;
    over_issue = issue_fire && !issue_ok;
  end
  assign out_valid = count != '0;
  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_class = out_valid ? mem_class[rd_ptr] : 3'd0;
  assign out_exception = out_valid && mem_exception[rd_ptr];
  assign issue_ok = !rst && (SW'(count) + SW'(inflight)) < depth_sum;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= fpu_result;
      mem_class[wr_ptr] <= cls;
      mem_exception[wr_ptr] <= fpu_exception;
    end
  end
  // Untracked results (e.g. from ops issued before reset) never enter the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      inflight <= '0;
      sticky_flags <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == last_ptr ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == last_ptr ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      inflight <= issue_fire && !fpu_valid ? (inflight == inflight_max ? inflight : inflight + 1'b1)
                : tracked && !issue_fire ? inflight - 1'b1
                : inflight;
      sticky_flags <= (flags_clear ? 4'b0 : sticky_flags)
                    | {drop || stray || over_issue, push && cls == 3'd3,
                       push && (cls == 3'd4 || cls == 3'd5), push && fpu_exception};
    end
  end
endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb_fpu_result_buffer: table-driven classification vectors plus scoreboarded FIFO corner sequences.
module tb_fpu_result_buffer;
  localparam int EW = 8, MW = 23, DEPTH = 4, W = EW + MW + 1, CW = $clog2(DEPTH + 1);
  logic clk = 0, rst = 1, issue_fire = 0, fpu_valid = 0, fpu_exception = 0, out_ready = 0, flags_clear = 0;
  logic [W-1:0] fpu_result = '0;
  logic issue_ok, out_valid, out_exception;
  logic [W-1:0] out_result;
  logic [2:0] out_class;
  logic [CW-1:0] count;
  logic [3:0] sticky_flags;
  typedef struct {
    logic [W-1:0] res;
    logic exc;
    logic [2:0] cls;
  } vec_t;
  vec_t exp_q[$];
  vec_t vecs[12];
  int nvec = 0, nfail = 0;
  always #5 clk = ~clk;
  fpu_result_buffer #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW), .DEPTH(DEPTH), .PIPE_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .issue_fire(issue_fire), .fpu_valid(fpu_valid), .fpu_result(fpu_result),
    .fpu_exception(fpu_exception), .issue_ok(issue_ok), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_class(out_class), .out_exception(out_exception), .count(count),
    .sticky_flags(sticky_flags), .flags_clear(flags_clear)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [W-1:0] r, input logic e, input logic [2:0] c);
    issue_fire = 1;
    tick;
    issue_fire = 0;
    tick;
    fpu_valid = 1;
    fpu_result = r;
    fpu_exception = e;
    exp_q.push_back('{r, e, c});
    tick;
    fpu_valid = 0;
    fpu_exception = 0;
  endtask
  task automatic deliver(input int n);
    for (int i = 0; i < n; i++) begin
      fpu_valid = 1;
      fpu_result = 32'h4000_0000 + i;
      exp_q.push_back('{32'h4000_0000 + i, 1'b0, 3'd2});
      tick;
    end
    fpu_valid = 0;
  endtask
  task automatic fill(input int n);
    issue_fire = 1;
    repeat (n) tick;
    issue_fire = 0;
    deliver(n);
  endtask
  task automatic pop_check(input string name);
    vec_t e;
    chk({name, "_valid"}, 32'(out_valid), 1);
    if (exp_q.size() == 0) begin
      nvec++;
      nfail++;
      $display("FAIL %s_sb: scoreboard empty while popping", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_res"}, out_result, e.res);
      chk({name, "_cls"}, 32'(out_class), 32'(e.cls));
      chk({name, "_exc"}, 32'(out_exception), 32'(e.exc));
    end
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask
  task automatic clear_flags;
    flags_clear = 1;
    tick;
    flags_clear = 0;
  endtask
  initial begin
    vec_t e;
    int n;
    vecs = '{'{32'h0000_0000, 1'b0, 3'd0}, '{32'h0000_0001, 1'b0, 3'd1}, '{32'h7F80_0000, 1'b0, 3'd3},
             '{32'h7FC0_0000, 1'b0, 3'd4}, '{32'h7F80_0001, 1'b0, 3'd5}, '{32'h8000_0000, 1'b0, 3'd0},
             '{32'h807F_FFFF, 1'b0, 3'd1}, '{32'hFF80_0000, 1'b0, 3'd3}, '{32'h0080_0000, 1'b0, 3'd2},
             '{32'h7F7F_FFFF, 1'b0, 3'd2}, '{32'hFFFF_FFFF, 1'b0, 3'd4}, '{32'h7FBF_FFFF, 1'b0, 3'd5}};
    tick;
    tick;
    chk("issue_ok_in_rst", 32'(issue_ok), 0);
    rst = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_result", out_result, 0);
    chk("rst_class", 32'(out_class), 0);
    chk("rst_exc", 32'(out_exception), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_sticky", 32'(sticky_flags), 0);
    chk("rst_issue_ok", 32'(issue_ok), 1);
    op(32'h3F80_0000, 1'b0, 3'd2);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_class", 32'(out_class), 2);
    chk("t1_count", 32'(count), 1);
    pop_check("t1");
    chk("t1_count_after", 32'(count), 0);
    for (int i = 0; i < 12; i++) begin
      op(vecs[i].res, vecs[i].exc, vecs[i].cls);
      chk($sformatf("t2_v%0d_class", i), 32'(out_class), 32'(vecs[i].cls));
      pop_check($sformatf("t2_v%0d", i));
    end
    chk("t2_sticky", 32'(sticky_flags), 32'h6);
    clear_flags;
    chk("t2_cleared", 32'(sticky_flags), 0);
    op(32'h3F80_0000, 1'b1, 3'd2);
    chk("t2_exc_sticky", 32'(sticky_flags), 32'h1);
    pop_check("t2_exc");
    issue_fire = 1;
    tick;
    issue_fire = 0;
    tick;
    fpu_valid = 1;
    fpu_result = 32'h7FC0_0000;
    flags_clear = 1;
    exp_q.push_back('{32'h7FC0_0000, 1'b0, 3'd4});
    tick;
    fpu_valid = 0;
    flags_clear = 0;
    chk("set_beats_clear", 32'(sticky_flags), 32'h2);
    pop_check("t2_nan");
    clear_flags;
    n = 0;
    for (int g = 0; g < 3 * DEPTH && issue_ok; g++) begin
      issue_fire = 1;
      tick;
      n++;
    end
    issue_fire = 0;
    chk("t3_issues", n, DEPTH);
    chk("t3_issue_ok_low", 32'(issue_ok), 0);
    deliver(DEPTH);
    tick;
    chk("t3_count", 32'(count), DEPTH);
    chk("t3_no_drop", 32'(sticky_flags[3]), 0);
    chk("t3_issue_ok_full", 32'(issue_ok), 0);
    issue_fire = 1;
    tick;
    issue_fire = 0;
    fpu_valid = 1;
    fpu_result = 32'h4100_0000;
    out_ready = 1;
    e = exp_q.pop_front();
    chk("t4_head", out_result, e.res);
    exp_q.push_back('{32'h4100_0000, 1'b0, 3'd2});
    tick;
    fpu_valid = 0;
    out_ready = 0;
    chk("t4_count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("t4_drain%0d", i));
    chk("t4_empty", 32'(count), 0);
    clear_flags;
    fill(DEPTH);
    fpu_valid = 1;
    fpu_result = 32'hDEAD_BEEF;
    tick;
    fpu_valid = 0;
    chk("t5_count", 32'(count), DEPTH);
    chk("t5_drop_flag", 32'(sticky_flags[3]), 1);
    clear_flags;
    chk("t5_cleared", 32'(sticky_flags), 0);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("t5_drain%0d", i));
    fill(3);
    issue_fire = 1;
    tick;
    tick;
    issue_fire = 0;
    chk("t6_pre_count", 32'(count), 3);
    rst = 1;
    tick;
    chk("t6_issue_ok_in_rst", 32'(issue_ok), 0);
    rst = 0;
    #1;
    exp_q.delete();
    chk("t6_count", 32'(count), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_issue_ok", 32'(issue_ok), 1);
    fpu_valid = 1;
    fpu_result = 32'h3F80_0000;
    tick;
    fpu_valid = 0;
    chk("t6_late_discarded", 32'(count), 0);
    chk("t6_late_flag", 32'(sticky_flags[3]), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
